// File: rtl/adpll_cfg_seq.sv
// ADPLL bring-up sequencer: writes soft reset/FCW/mode/enable, polls lock, disables on stop or timeout.
// Optional leading soft-reset write is enabled by defining ADPLL_SEQ_SOFT_RST_EN.
`timescale 1ns/1ps

`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h10
`endif
`ifndef FCW
`define FCW 'h11
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h12
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h13
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h14
`endif

module adpll_cfg_seq #(
  parameter int unsigned POLL_GAP  = 64,
  parameter int unsigned MAX_POLLS = 1024,
  parameter int unsigned RDY_TO    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [`FCWW-1:0]         fcw_in,
  input  logic [1:0]               mode_in,
  output logic                     valid,
  output logic [`ADPLL_ADDR_W-1:0] address,
  output logic [31:0]              wdata,
  output logic                     wstrb,
  input  logic [31:0]              rdata,
  input  logic                     ready,
  output logic                     busy,
  output logic                     locked,
  output logic                     done,
  output logic [1:0]               err
);

  localparam int unsigned AW = `ADPLL_ADDR_W;
  localparam int unsigned FW = `FCWW;
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam int unsigned TW = $clog2(RDY_TO + 1);

  typedef enum logic [3:0] {
    IDLE,
`ifdef ADPLL_SEQ_SOFT_RST_EN
    SRST,
`endif
    WFCW, WMODE, WEN, RLOCK, PWAIT, LOCKED, DIS
  } state_t;

  state_t          state;
  state_t          req_next;
  logic [FW-1:0]   fcw_q;
  logic [1:0]      mode_q;
  logic            abort;
  logic [PW-1:0]   poll_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   rto_cnt;
  logic [AW-1:0]   req_addr;
  logic [31:0]     req_data;
  logic            req_wr;
  logic            abort_now;
  logic            unused_rdata;

  assign abort_now    = abort | stop;
  assign unused_rdata = ^rdata[31:1];

  // Bus request and successor for each transaction state
  always_comb begin
    req_addr = '0;
    req_data = '0;
    req_wr   = 1'b1;
    req_next = IDLE;
    case (state)
`ifdef ADPLL_SEQ_SOFT_RST_EN
      SRST:  begin req_addr = AW'(`ADPLL_SOFT_RST); req_data = 32'd1; req_next = WFCW; end
`endif
      WFCW:  begin req_addr = AW'(`FCW);        req_data = 32'(fcw_q);  req_next = WMODE; end
      WMODE: begin req_addr = AW'(`ADPLL_MODE); req_data = 32'(mode_q); req_next = WEN;   end
      WEN:   begin req_addr = AW'(`ADPLL_EN);   req_data = 32'd1;       req_next = RLOCK; end
      RLOCK: begin req_addr = AW'(`ADPLL_LOCK); req_wr   = 1'b0; end
      DIS:   begin req_addr = AW'(`ADPLL_EN);   req_data = 32'd0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      address  <= '0;
      wdata    <= '0;
      wstrb    <= 1'b0;
      busy     <= 1'b0;
      locked   <= 1'b0;
      done     <= 1'b0;
      err      <= 2'd0;
      fcw_q    <= '0;
      mode_q   <= '0;
      abort    <= 1'b0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      rto_cnt  <= '0;
    end else begin
      done <= 1'b0;
      // A stop during the disable write itself is already being honoured
      if (stop && state != IDLE && state != DIS) begin
        abort  <= 1'b1;
        locked <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start && !stop) begin
            fcw_q    <= fcw_in;
            mode_q   <= mode_in;
            locked   <= 1'b0;
            err      <= 2'd0;
            abort    <= 1'b0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            rto_cnt  <= '0;
            busy     <= 1'b1;
            valid    <= 1'b1;
            wstrb    <= 1'b1;
`ifdef ADPLL_SEQ_SOFT_RST_EN
            address  <= AW'(`ADPLL_SOFT_RST);
            wdata    <= 32'd1;
            state    <= SRST;
`else
            address  <= AW'(`FCW);
            wdata    <= 32'(fcw_in);
            state    <= WFCW;
`endif
          end
        end
        PWAIT: begin
          if (abort_now) begin
            state   <= DIS;
            gap_cnt <= '0;
          end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= RLOCK;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        LOCKED: begin
          if (stop) state <= DIS;
        end
        default: begin
          // Bus states: issue after the idle cycle, hold until ready, else time out
          if (!valid) begin
            if (abort_now && state != DIS) begin
              state <= DIS;
            end else begin
              valid   <= 1'b1;
              address <= req_addr;
              wdata   <= req_data;
              wstrb   <= req_wr;
              rto_cnt <= '0;
            end
          end else if (ready) begin
            valid   <= 1'b0;
            rto_cnt <= '0;
            if (state == DIS) begin
              state <= IDLE;
              busy  <= 1'b0;
              abort <= 1'b0;
              done  <= abort;
            end else if (abort_now) begin
              state <= DIS;
            end else if (state == RLOCK) begin
              if (rdata[0]) begin
                locked <= 1'b1;
                done   <= 1'b1;
                state  <= LOCKED;
              end else if (poll_cnt == PW'(MAX_POLLS - 1)) begin
                poll_cnt <= poll_cnt + PW'(1);
                err      <= 2'd1;
                done     <= 1'b1;
                state    <= DIS;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
                state    <= PWAIT;
              end
            end else begin
              state <= req_next;
            end
          end else if (rto_cnt == TW'(RDY_TO - 1)) begin
            valid   <= 1'b0;
            rto_cnt <= '0;
            err     <= 2'd2;
            done    <= 1'b1;
            locked  <= 1'b0;
            busy    <= 1'b0;
            abort   <= 1'b0;
            state   <= IDLE;
          end else begin
            rto_cnt <= rto_cnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Scoreboard bench for adpll_cfg_seq: expected bus writes/reads and done events queued from a transaction-level model.
`timescale 1ns/1ps

`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 'h10
`endif
`ifndef FCW
`define FCW 'h11
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 'h12
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 'h13
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 'h14
`endif

module tb_adpll_cfg_seq;
  localparam int unsigned POLL_GAP  = 2;
  localparam int unsigned MAX_POLLS = 4;
  localparam int unsigned RDY_TO    = 15;
  localparam int unsigned AW = `ADPLL_ADDR_W;
  localparam int unsigned FW = `FCWW;
`ifdef ADPLL_SEQ_SOFT_RST_EN
  localparam int unsigned NWR = 4;
`else
  localparam int unsigned NWR = 3;
`endif
  localparam int unsigned FIRST_READ = 3 * NWR;

  logic          clk, rst, start, stop;
  logic [FW-1:0] fcw_in;
  logic [1:0]    mode_in;
  logic          valid, wstrb, ready, busy, locked, done;
  logic [AW-1:0] address;
  logic [31:0]   wdata, rdata;
  logic [1:0]    err;

  adpll_cfg_seq #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS), .RDY_TO(RDY_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fcw_in(fcw_in), .mode_in(mode_in),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
    .ready(ready), .busy(busy), .locked(locked), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register slave: ready registered from valid; lock reported from the lock_after-th read onward
  logic        hold;
  int unsigned lock_after;
  int unsigned reads_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready      <= 1'b0;
      reads_done <= 0;
    end else begin
      ready <= valid && !hold;
      if (start && !busy) reads_done <= 0;
      else if (valid && ready && address == AW'(`ADPLL_LOCK)) reads_done <= reads_done + 1;
    end
  end
  always_comb rdata = {31'd0, (lock_after != 0 && reads_done + 1 >= lock_after)};

  typedef struct {
    bit          is_done;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [1:0]  e;
    logic        lk;
  } ev_t;
  ev_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bus(input int unsigned a, input logic [31:0] d, input logic w);
    ev_t e;
    e.is_done = 1'b0; e.addr = AW'(a); e.data = d; e.wr = w; e.e = 2'd0; e.lk = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] ec, input logic lk);
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.wr = 1'b0; e.e = ec; e.lk = lk;
    exp_q.push_back(e);
  endtask

  // Transaction-level model of one bring-up attempt
  task automatic model_run(input logic [FW-1:0] f, input logic [1:0] m, input int unsigned la);
    int unsigned n;
    n = (la == 0 || la > MAX_POLLS) ? MAX_POLLS : la;
`ifdef ADPLL_SEQ_SOFT_RST_EN
    push_bus(`ADPLL_SOFT_RST, 32'd1, 1'b1);
`endif
    push_bus(`FCW, {{(32-FW){1'b0}}, f}, 1'b1);
    push_bus(`ADPLL_MODE, {30'd0, m}, 1'b1);
    push_bus(`ADPLL_EN, 32'd1, 1'b1);
    for (int i = 0; i < int'(n); i++) push_bus(`ADPLL_LOCK, 32'd0, 1'b0);
    if (n == la) push_done(2'd0, 1'b1);
    else begin
      push_done(2'd1, 1'b0);
      push_bus(`ADPLL_EN, 32'd0, 1'b1);
    end
  endtask

  // Monitor: pops and compares on every completed transaction and every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if ((valid && ready) || done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual valid=%0b addr=%0h done=%0b expected none t=%0t",
                   valid, address, done, $time);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", 32'(done), 32'(e.is_done));
          if (e.is_done) begin
            chk("done_err", 32'(err), 32'(e.e));
            chk("done_locked", 32'(locked), 32'(e.lk));
          end else begin
            chk("bus_addr", 32'(address), 32'(e.addr));
            chk("bus_wdata", wdata, e.data);
            chk("bus_wstrb", 32'(wstrb), 32'(e.wr));
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [FW-1:0] f, input logic [1:0] m);
    @(negedge clk);
    fcw_in = f; mode_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_address"}, 32'(address), 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wstrb"}, 32'(wstrb), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Full attempt: latency, poll spacing and read count, then stop if locked
  task automatic run_seq(input logic [FW-1:0] f, input logic [1:0] m, input int unsigned la);
    int n = 0, nreads = 0, first = -1, last = -1;
    int unsigned nexp;
    logic pv = 1'b0;
    bit   exp_lock;
    nexp = (la == 0 || la > MAX_POLLS) ? MAX_POLLS : la;
    exp_lock = (nexp == la);
    lock_after = la;
    model_run(f, m, la);
    pulse_start(f, m);
    chk("valid_after_start", 32'(valid), 1);
    while (!locked && busy && n < 400) begin
      if (valid && !pv && address == AW'(`ADPLL_LOCK)) begin
        if (first < 0) first = n;
        else chk("poll_period", 32'(n - last), 32'(3 + POLL_GAP));
        last = n;
        nreads++;
      end
      pv = valid;
      @(negedge clk);
      n++;
    end
    chk("first_read_latency", 32'(first), 32'(FIRST_READ));
    chk("read_count", 32'(nreads), nexp);
    if (exp_lock) begin
      chk("locked_level", 32'(locked), 1);
      repeat (3) @(negedge clk);
      chk("locked_busy_hold", 32'(busy), 1);
      push_bus(`ADPLL_EN, 32'd0, 1'b1);
      push_done(2'd0, 1'b0);
      pulse_stop();
      wait_idle(50);
      chk("locked_after_stop", 32'(locked), 0);
    end else begin
      wait_idle(50);
      chk("timeout_err", 32'(err), 1);
      chk("timeout_locked", 32'(locked), 0);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic act;
    rst = 1'b1; start = 1'b0; stop = 1'b0; fcw_in = '0; mode_in = '0;
    hold = 1'b0; lock_after = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Nominal lock on the 3rd read
    run_seq(26'h2620000, 2'd1, 3);

    // Poll timeout: lock never reported
    run_seq(26'h1234567, 2'd2, 0);

    // Stop during the second valid cycle of the FCW write
    lock_after = 1;
`ifdef ADPLL_SEQ_SOFT_RST_EN
    push_bus(`ADPLL_SOFT_RST, 32'd1, 1'b1);
`endif
    push_bus(`FCW, 32'h0155AA, 1'b1);
    push_bus(`ADPLL_EN, 32'd0, 1'b1);
    push_done(2'd0, 1'b0);
    pulse_start(26'h0155AA, 2'd3);
    n = 0;
    while (!(valid && address == AW'(`FCW)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fcw_write_seen", 32'(valid && address == AW'(`FCW)), 1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(50);
    chk("stop_locked", 32'(locked), 0);
    chk("stop_err", 32'(err), 0);
    repeat (2) @(negedge clk);
    chk("stop_queue_drained", 32'(exp_q.size()), 0);

    // Bus timeout: slave never acknowledges
    hold = 1'b1;
    push_done(2'd2, 1'b0);
    pulse_start(26'h3FFFFFF, 2'd0);
    n = 0;
    while (valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bus_to_valid_cycles", 32'(n), 32'(RDY_TO));
    chk("bus_to_err", 32'(err), 2);
    chk("bus_to_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    hold = 1'b0;
    chk("bus_to_queue_drained", 32'(exp_q.size()), 0);

    // Start and stop together in IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    act = 1'b0;
    repeat (10) begin
      if (valid || busy) act = 1'b1;
      @(negedge clk);
    end
    chk("start_stop_no_activity", 32'(act), 0);

    // Asynchronous reset while waiting between polls
    lock_after = 0;
    model_run(26'h0ABCDEF, 2'd1, 0);
    pulse_start(26'h0ABCDEF, 2'd1);
    n = 0;
    while (!(valid && ready && address == AW'(`ADPLL_LOCK)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pwait_read_seen", 32'(valid && ready), 1);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_seq(26'h2620000, 2'd1, 3);

    // Randomized attempts
    for (int k = 0; k < 4; k++) begin
      logic [FW-1:0] f;
      logic [1:0]    m;
      int unsigned   la;
      f  = FW'($urandom);
      m  = 2'($urandom_range(0, 3));
      la = $urandom_range(0, MAX_POLLS + 1);
      run_seq(f, m, la);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
